// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - core/DMA arbiter for the single-port data SRAM
// Optional starvation guard enabled by defining SRAM_ARB_STARVE_EN.
module sram_arbiter #(
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        core_req,
   input  logic        core_we,
   input  logic [3:0]  core_ben,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_din,
   output logic [31:0] core_dout,
   output logic        core_stall,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [3:0]  dma_ben,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_din,
   output logic        dma_gnt,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic        sram_cen,
   output logic        sram_wen,
   output logic [3:0]  sram_ben,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_din,
   input  logic [31:0] sram_dout
);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CORE = 2'd1;
   localparam logic [1:0] OWN_DMA  = 2'd2;

   if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
      $error("sram_arbiter: STARVE_MAX must be in 1..255");
   end

   logic [1:0] owner;
   logic [1:0] rd_owner_q, rd_owner_d;
   logic       force_dma;

`ifdef SRAM_ARB_STARVE_EN
   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_FORCE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign force_dma  = (state_q == ST_FORCE);
   assign core_stall = force_dma;

   always_comb begin
      cnt_d = cnt_q;
      if (!dma_req || dma_gnt) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end

      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (dma_req && !dma_gnt) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A grant in the same cycle the limit is hit wins over forcing.
            if (dma_gnt || !dma_req)  state_d = ST_IDLE;
            else if (cnt_q == CNT_MAX) state_d = ST_FORCE;
         end
         ST_FORCE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   assign force_dma  = 1'b0;
   assign core_stall = 1'b0;
`endif

   // Reset gates the owner so the SRAM is idle for the whole reset window.
   always_comb begin
      owner = OWN_NONE;
      if (!rst) begin
         if (force_dma)     owner = OWN_DMA;
         else if (core_req) owner = OWN_CORE;
         else if (dma_req)  owner = OWN_DMA;
      end
   end

   assign dma_gnt = (owner == OWN_DMA);

   always_comb begin
      sram_cen  = 1'b1;
      sram_wen  = 1'b1;
      sram_ben  = 4'b1111;
      sram_addr = '0;
      sram_din  = '0;
      case (owner)
         OWN_CORE: begin
            sram_cen  = 1'b0;
            sram_wen  = ~core_we;
            sram_ben  = core_ben;
            sram_addr = core_addr;
            sram_din  = core_din;
         end
         OWN_DMA: begin
            sram_cen  = 1'b0;
            sram_wen  = ~dma_we;
            sram_ben  = dma_ben;
            sram_addr = dma_addr;
            sram_din  = dma_din;
         end
         default: ;
      endcase
   end

   always_comb begin
      rd_owner_d = OWN_NONE;
      if (owner == OWN_CORE && !core_we) rd_owner_d = OWN_CORE;
      else if (owner == OWN_DMA && !dma_we) rd_owner_d = OWN_DMA;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_owner_q <= OWN_NONE;
      else     rd_owner_q <= rd_owner_d;
   end

   assign dma_rvalid = (rd_owner_q == OWN_DMA);
   assign dma_rdata  = sram_dout;
   assign core_dout  = sram_dout;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
// Expectations follow SRAM_ARB_STARVE_EN as defined for the build.
module tb_sram_arbiter;

`ifdef SRAM_ARB_STARVE_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req, core_we;
   logic [3:0]  core_ben;
   logic [31:0] core_addr, core_din, core_dout;
   logic        core_stall;
   logic        dma_req, dma_we;
   logic [3:0]  dma_ben;
   logic [31:0] dma_addr, dma_din;
   logic        dma_gnt, dma_rvalid;
   logic [31:0] dma_rdata;
   logic        sram_cen, sram_wen;
   logic [3:0]  sram_ben;
   logic [31:0] sram_addr, sram_din;
   logic [31:0] sram_dout;

   int n_cmp = 0;
   int n_bad = 0;

   sram_arbiter #(.STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_ben(core_ben),
      .core_addr(core_addr), .core_din(core_din), .core_dout(core_dout),
      .core_stall(core_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_ben(dma_ben),
      .dma_addr(dma_addr), .dma_din(dma_din), .dma_gnt(dma_gnt),
      .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_ben(sram_ben),
      .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural single-port SRAM: read-first, one-cycle read latency.
   logic [31:0] mem [0:63];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) mem[i] <= {8'hA5, 8'(i), 16'h1234 ^ 16'(i * 7)};
         mem[16]   <= 32'hDEADBEEF;
         sram_dout <= 32'h0;
      end else if (!sram_cen) begin
         sram_dout <= mem[sram_addr[7:2]];
         if (!sram_wen)
            for (int b = 0; b < 4; b++)
               if (!sram_ben[b]) mem[sram_addr[7:2]][8*b +: 8] <= sram_din[8*b +: 8];
      end
   end

   // Scoreboard: expected read data queued at issue, compared on return.
   logic [31:0] dma_q [$];
   logic        core_pend;
   logic [31:0] core_exp;
   always @(negedge clk) begin
      if (rst) begin
         dma_q.delete();
         core_pend = 1'b0;
      end else begin
         check("dma_rvalid_vs_pending", dma_rvalid, (dma_q.size() != 0) ? 1 : 0);
         if (dma_q.size() != 0) begin
            if (dma_rvalid) check("sb_dma_rdata", dma_rdata, dma_q.pop_front());
            else            void'(dma_q.pop_front());
         end
         if (core_pend) check("sb_core_dout", core_dout, core_exp);
         core_pend = core_req && !core_we && !core_stall;
         core_exp  = mem[core_addr[7:2]];
         if (dma_gnt && !dma_we) dma_q.push_back(mem[dma_addr[7:2]]);
      end
   end

   typedef struct {
      logic        c_req, c_we;
      logic [3:0]  c_ben;
      logic [31:0] c_addr, c_din;
      logic        d_req, d_we;
      logic [3:0]  d_ben;
      logic [31:0] d_addr, d_din;
      logic        e_cen, e_wen, e_gnt;
      logic [3:0]  e_ben;
      logic [31:0] e_addr, e_din;
   } vec_t;

   vec_t vecs [7];

   task automatic idle_inputs();
      core_req = 1'b0; core_we = 1'b0; core_ben = 4'hF; core_addr = '0; core_din = '0;
      dma_req  = 1'b0; dma_we  = 1'b0; dma_ben  = 4'hF; dma_addr  = '0; dma_din  = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_bus(input string tag);
      check({tag, "_cen"}, sram_cen, 1);
      check({tag, "_wen"}, sram_wen, 1);
      check({tag, "_ben"}, sram_ben, 4'hF);
      check({tag, "_addr"}, sram_addr, 0);
      check({tag, "_gnt"}, dma_gnt, 0);
      check({tag, "_stall"}, core_stall, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_force;
      logic got;

      vecs[0] = '{1'b0,1'b0,4'hF,32'h0,32'h0,         1'b0,1'b0,4'hF,32'h0,32'h0,         1'b1,1'b1,1'b0,4'hF,32'h0,32'h0};
      vecs[1] = '{1'b1,1'b0,4'h0,32'h08,32'h0,        1'b0,1'b0,4'hF,32'h0,32'h0,         1'b0,1'b1,1'b0,4'h0,32'h08,32'h0};
      vecs[2] = '{1'b1,1'b1,4'h0,32'h10,32'h11112222, 1'b0,1'b0,4'hF,32'h0,32'h0,         1'b0,1'b0,1'b0,4'h0,32'h10,32'h11112222};
      vecs[3] = '{1'b0,1'b0,4'hF,32'h0,32'h0,         1'b1,1'b1,4'hC,32'h20,32'h33334444, 1'b0,1'b0,1'b1,4'hC,32'h20,32'h33334444};
      vecs[4] = '{1'b1,1'b1,4'h3,32'h14,32'h55556666, 1'b1,1'b0,4'h0,32'h44,32'h0,        1'b0,1'b0,1'b0,4'h3,32'h14,32'h55556666};
      vecs[5] = '{1'b0,1'b0,4'hF,32'h0,32'h0,         1'b1,1'b0,4'h0,32'h48,32'h0,        1'b0,1'b1,1'b1,4'h0,32'h48,32'h0};
      vecs[6] = '{1'b1,1'b0,4'h0,32'h20,32'h0,        1'b1,1'b1,4'h0,32'h24,32'h77778888, 1'b0,1'b1,1'b0,4'h0,32'h20,32'h0};

      rst = 1'b1;
      idle_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rvalid", dma_rvalid, 0);
      check_idle_bus("rst");
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check_idle_bus("post_rst");

      // DMA read on an idle bus
      next_cycle();
      dma_req = 1'b1; dma_we = 1'b0; dma_ben = 4'h0; dma_addr = 32'h40;
      @(negedge clk);
      check("dmard_gnt", dma_gnt, 1);
      check("dmard_cen", sram_cen, 0);
      check("dmard_addr", sram_addr, 32'h40);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check("dmard_rvalid", dma_rvalid, 1);
      check("dmard_rdata", dma_rdata, 32'hDEADBEEF);

      for (int v = 0; v < 7; v++) begin
         next_cycle();
         core_req = vecs[v].c_req; core_we = vecs[v].c_we; core_ben = vecs[v].c_ben;
         core_addr = vecs[v].c_addr; core_din = vecs[v].c_din;
         dma_req = vecs[v].d_req; dma_we = vecs[v].d_we; dma_ben = vecs[v].d_ben;
         dma_addr = vecs[v].d_addr; dma_din = vecs[v].d_din;
         @(negedge clk);
         check($sformatf("vec%0d_cen", v), sram_cen, vecs[v].e_cen);
         check($sformatf("vec%0d_wen", v), sram_wen, vecs[v].e_wen);
         check($sformatf("vec%0d_ben", v), sram_ben, vecs[v].e_ben);
         check($sformatf("vec%0d_addr", v), sram_addr, vecs[v].e_addr);
         check($sformatf("vec%0d_din", v), sram_din, vecs[v].e_din);
         check($sformatf("vec%0d_gnt", v), dma_gnt, vecs[v].e_gnt);
         check($sformatf("vec%0d_stall", v), core_stall, 0);
         next_cycle();
         idle_inputs();
      end

      // Collision: core wins, DMA granted the first cycle core_req drops
      next_cycle();
      core_req = 1'b1; core_we = 1'b1; core_ben = 4'h0; core_addr = 32'h10; core_din = 32'h9999AAAA;
      dma_req = 1'b1; dma_we = 1'b0; dma_ben = 4'h0; dma_addr = 32'h4C;
      @(negedge clk);
      check("coll_addr", sram_addr, 32'h10);
      check("coll_gnt", dma_gnt, 0);
      next_cycle();
      core_req = 1'b0;
      @(negedge clk);
      check("coll_gnt_next", dma_gnt, 1);
      check("coll_addr_next", sram_addr, 32'h4C);
      next_cycle();
      idle_inputs();

      // Starvation: core reads every cycle while the DMA waits
      next_cycle();
      core_req = 1'b1; core_we = 1'b0; core_ben = 4'h0; core_addr = 32'h4;
      dma_req = 1'b1; dma_we = 1'b0; dma_ben = 4'h0; dma_addr = 32'h50;
      got = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         exp_force = GUARD && (c == 5);
         check($sformatf("starve_c%0d_stall", c), core_stall, exp_force);
         check($sformatf("starve_c%0d_gnt", c), dma_gnt, exp_force);
         check($sformatf("starve_c%0d_addr", c), sram_addr, exp_force ? 32'h50 : 32'h4);
         if (dma_gnt) got = 1'b1;
         next_cycle();
         if (got) dma_req = 1'b0;
      end
      core_req = 1'b0;
      @(negedge clk);
      check("starve_release_gnt", dma_gnt, GUARD ? 0 : 1);
      check("starve_release_stall", core_stall, 0);
      next_cycle();
      idle_inputs();

      // Interleave core and DMA reads each cycle
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         if (i % 2 == 0) begin
            core_req = 1'b1; core_we = 1'b0; core_ben = 4'h0; core_addr = 32'h60 + 32'(4 * i);
            dma_req = 1'b0;
         end else begin
            core_req = 1'b0;
            dma_req = 1'b1; dma_we = 1'b0; dma_ben = 4'h0; dma_addr = 32'h80 + 32'(4 * i);
         end
         @(negedge clk);
         check($sformatf("ilv%0d_gnt", i), dma_gnt, (i % 2) ? 1 : 0);
         check($sformatf("ilv%0d_rvalid", i), dma_rvalid, (i % 2 == 0 && i > 0) ? 1 : 0);
      end
      next_cycle();
      idle_inputs();
      next_cycle();

      // Reset while a DMA read response is in flight
      dma_req = 1'b1; dma_we = 1'b0; dma_ben = 4'h0; dma_addr = 32'h40;
      @(negedge clk);
      check("rstmid_gnt_before", dma_gnt, 1);
      next_cycle();
      check("rstmid_rvalid_before", dma_rvalid, 1);
      rst = 1'b1;
      #1;
      check("rstmid_rvalid", dma_rvalid, 0);
      check("rstmid_cen", sram_cen, 1);
      check("rstmid_wen", sram_wen, 1);
      check("rstmid_ben", sram_ben, 4'hF);
      check("rstmid_gnt", dma_gnt, 0);
      check("rstmid_stall", core_stall, 0);
      idle_inputs();
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_after_rvalid", dma_rvalid, 0);
      check_idle_bus("rstmid_after");

      next_cycle();
      next_cycle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
